alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 212 +++++++++++++++++++++
 tb/tb_alu_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: 8-bit multi-cycle ALU with shift-add multiply and
// iterative shift-left, writing its result back to reg3.
module alu_core (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [7:0] operanda,
    input  logic [7:0] operandb,
    output logic       busy,
    output logic       done,
    output logic       save,
    output logic [2:0] saveselector,
    output logic [7:0] savebus,
    output logic       zero,
    output logic       carry,
    output logic       negative
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MULT,
        SHIFT,
        WRITE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  op_q, op_n;
    logic [7:0]  a_q, a_n;
    logic [7:0]  b_q, b_n;
    logic [15:0] acc, acc_n;
    logic [15:0] mcand, mcand_n;
    logic [7:0]  mplier, mplier_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  sh, sh_n;
    logic [7:0]  res, res_n;
    logic        cy_n;
    logic        wr;
    logic [8:0]  sum9;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        a_n      = a_q;
        b_n      = b_q;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        sh_n     = sh;
        res_n    = res;
        cy_n     = carry;
        wr       = 1'b0;
        sum9     = 9'h000;
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_n    = opcode;
                    a_n     = operanda;
                    b_n     = operandb;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                unique case (op_q)
                    OP_ADD: begin
                        sum9  = {1'b0, a_q} + {1'b0, b_q};
                        res_n = sum9[7:0];
                        cy_n  = sum9[8];
                        wr    = 1'b1;
                    end
                    OP_SUB: begin
                        res_n = a_q - b_q;
                        cy_n  = (a_q < b_q);
                        wr    = 1'b1;
                    end
                    OP_AND: begin
                        res_n = a_q & b_q;
                        cy_n  = 1'b0;
                        wr    = 1'b1;
                    end
                    OP_OR: begin
                        res_n = a_q | b_q;
                        cy_n  = 1'b0;
                        wr    = 1'b1;
                    end
                    OP_XOR: begin
                        res_n = a_q ^ b_q;
                        cy_n  = 1'b0;
                        wr    = 1'b1;
                    end
                    OP_NOT: begin
                        res_n = ~a_q;
                        cy_n  = 1'b0;
                        wr    = 1'b1;
                    end
                    OP_MUL: begin
                        acc_n    = 16'h0000;
                        mcand_n  = {8'h00, a_q};
                        mplier_n = b_q;
                        cnt_n    = 4'd8;
                        state_n  = MULT;
                    end
                    OP_SHL: begin
                        if (b_q[2:0] == 3'b000) begin
                            res_n = a_q;
                            cy_n  = 1'b0;
                            wr    = 1'b1;
                        end else begin
                            sh_n    = a_q;
                            cnt_n   = {1'b0, b_q[2:0]};
                            state_n = SHIFT;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
            MULT: begin
                if (mplier[0]) begin
                    acc_n = acc + mcand;
                end
                mcand_n  = {mcand[14:0], 1'b0};
                mplier_n = {1'b0, mplier[7:1]};
                cnt_n    = cnt - 4'd1;
                // last multiplier bit: commit the final product directly
                if (cnt == 4'd1) begin
                    res_n = acc_n[7:0];
                    cy_n  = |acc_n[15:8];
                    wr    = 1'b1;
                end
            end
            SHIFT: begin
                sh_n  = {sh[6:0], 1'b0};
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    res_n = sh_n;
                    cy_n  = sh[7];
                    wr    = 1'b1;
                end
            end
            WRITE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (wr) begin
            state_n = WRITE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q   <= 3'b000;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            acc    <= 16'h0000;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            cnt    <= 4'd0;
            sh     <= 8'h00;
        end else begin
            op_q   <= op_n;
            a_q    <= a_n;
            b_q    <= b_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
        end
    end

    // result and flags change only on the edge that enters WRITE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res      <= 8'h00;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (wr) begin
            res      <= res_n;
            carry    <= cy_n;
            zero     <= (res_n == 8'h00);
            negative <= res_n[7];
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        save         = (state == WRITE);
        done         = (state == WRITE);
        saveselector = 3'b011;
        savebus      = (state == WRITE) ? res : 8'h00;
    end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table plus hand-written sequences
// for re-start, start-in-WRITE and mid-operation reset.
module tb_alu_core;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] operanda;
    logic [7:0] operandb;
    logic       busy;
    logic       done;
    logic       save;
    logic [2:0] saveselector;
    logic [7:0] savebus;
    logic       zero;
    logic       carry;
    logic       negative;

    int n_tests = 0;
    int n_fail  = 0;

    alu_core dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .opcode       (opcode),
        .operanda     (operanda),
        .operandb     (operandb),
        .busy         (busy),
        .done         (done),
        .save         (save),
        .saveselector (saveselector),
        .savebus      (savebus),
        .zero         (zero),
        .carry        (carry),
        .negative     (negative)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int cyc;
        @(negedge clock);
        opcode   = v.op;
        operanda = v.a;
        operandb = v.b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        opcode   = 3'($urandom);
        operanda = 8'($urandom);
        operandb = 8'($urandom);
        cyc = 1;
        chk($sformatf("v%0d busy", idx), 16'(busy), 16'd1);
        while (!save && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk($sformatf("v%0d latency", idx), 16'(cyc), 16'(v.lat));
        chk($sformatf("v%0d savebus", idx), 16'(savebus), 16'(v.res));
        chk($sformatf("v%0d carry", idx), 16'(carry), 16'(v.c));
        chk($sformatf("v%0d zero", idx), 16'(zero), 16'(v.z));
        chk($sformatf("v%0d negative", idx), 16'(negative), 16'(v.n));
        chk($sformatf("v%0d done", idx), 16'(done), 16'd1);
        chk($sformatf("v%0d savesel", idx), 16'(saveselector), 16'd3);
        @(posedge clock);
        #1;
        chk($sformatf("v%0d idle busy", idx), 16'(busy), 16'd0);
        chk($sformatf("v%0d idle save", idx), 16'(save), 16'd0);
        chk($sformatf("v%0d idle bus", idx), 16'(savebus), 16'd0);
        chk($sformatf("v%0d hold carry", idx), 16'(carry), 16'(v.c));
        chk($sformatf("v%0d hold zero", idx), 16'(zero), 16'(v.z));
    endtask

    initial begin
        int cyc;
        int dones;
        int wcyc;
        int bad;
        logic [7:0] wbus;

        vecs[0]  = '{3'b000, 8'd200, 8'd100, 2,  8'd44,  1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 8'd5,   8'd5,   2,  8'd0,   1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b001, 8'd3,   8'd5,   2,  8'd254, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3'b110, 8'd15,  8'd17,  10, 8'd255, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'b110, 8'd16,  8'd16,  10, 8'd0,   1'b1, 1'b1, 1'b0};
        vecs[5]  = '{3'b111, 8'h81,  8'd1,   3,  8'h02,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 8'h81,  8'd8,   2,  8'h81,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b010, 8'hF0,  8'h3C,  2,  8'h30,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b011, 8'h0F,  8'h80,  2,  8'h8F,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b100, 8'hAA,  8'hAA,  2,  8'h00,  1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 8'h0F,  8'h55,  2,  8'hF0,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b111, 8'h01,  8'd7,   9,  8'h80,  1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b111, 8'hC0,  8'd2,   4,  8'h00,  1'b1, 1'b1, 1'b0};
        vecs[13] = '{3'b110, 8'd255, 8'd255, 10, 8'h01,  1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'b000, 8'hFF,  8'h01,  2,  8'h00,  1'b1, 1'b1, 1'b0};
        vecs[15] = '{3'b110, 8'd0,   8'd99,  10, 8'h00,  1'b0, 1'b1, 1'b0};
        vecs[16] = '{3'b001, 8'd0,   8'd1,   2,  8'hFF,  1'b1, 1'b0, 1'b1};

        reset    = 1'b1;
        start    = 1'b0;
        opcode   = 3'b000;
        operanda = 8'h00;
        operandb = 8'h00;
        #12;
        chk("reset busy", 16'(busy), 16'd0);
        chk("reset done", 16'(done), 16'd0);
        chk("reset save", 16'(save), 16'd0);
        chk("reset savebus", 16'(savebus), 16'd0);
        chk("reset flags", 16'({zero, carry, negative}), 16'd0);
        chk("reset savesel", 16'(saveselector), 16'd3);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i], i);
        end

        // second start during MUL is ignored; one done pulse only
        @(negedge clock);
        opcode   = 3'b110;
        operanda = 8'd15;
        operandb = 8'd17;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc   = 1;
        dones = 0;
        wcyc  = 0;
        wbus  = 8'h00;
        while (cyc < 20) begin
            if (cyc == 4) begin
                start    = 1'b1;
                opcode   = 3'b000;
                operanda = 8'd1;
                operandb = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                wcyc = cyc;
                wbus = savebus;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk("restart done count", 16'(dones), 16'd1);
        chk("restart write cycle", 16'(wcyc), 16'd10);
        chk("restart savebus", 16'(wbus), 16'd255);
        chk("restart negative", 16'(negative), 16'd1);

        // start held during the WRITE cycle is ignored
        @(negedge clock);
        opcode   = 3'b010;
        operanda = 8'hFF;
        operandb = 8'h0F;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("wstart in write", 16'(save), 16'd1);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("wstart busy", 16'(busy), 16'd0);
        @(posedge clock);
        #1;
        chk("wstart still idle", 16'(busy), 16'd0);

        // prime nonzero flags, then reset in the middle of a MUL
        run_op(vecs[2], 100);
        @(negedge clock);
        opcode   = 3'b110;
        operanda = 8'd15;
        operandb = 8'd17;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clock);
            #1;
        end
        chk("abort busy before", 16'(busy), 16'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort busy", 16'(busy), 16'd0);
        chk("abort save", 16'(save), 16'd0);
        chk("abort savebus", 16'(savebus), 16'd0);
        chk("abort flags", 16'({zero, carry, negative}), 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            if (save || busy || done) bad++;
            @(posedge clock);
            #1;
        end
        chk("no resume", 16'(bad), 16'd0);
        chk("flags stay clear", 16'({zero, carry, negative}), 16'd0);

        run_op(vecs[0], 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
